// File: rtl/pipe_flow_ctrl_if.sv
// Op encoding shared by decode, this controller and the bench, plus the grouped stage-0/stage-1 bus.
// Latency: n/a (declarations only).
// Backpressure: n/a; stall/squash on this bus are how the controller holds or cancels upstream work.
// Ports (slave side = controller): in op0,d0,s0,t0,imm0,s1_wr,s1_dst,s2_wr,s2_dst,br_taken,br_target;
//   out pc,s1_op,s1_d,stall,squash,cs_depth,cs_err,halt.
package pipe_flow_ctrl_pkg;
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_AND    = 5'd1,
        OP_MUL    = 5'd2,
        OP_OR     = 5'd3,
        OP_SLL    = 5'd4,
        OP_SLT    = 5'd5,
        OP_SRA    = 5'd6,
        OP_XOR    = 5'd7,
        OP_LU8    = 5'd8,
        OP_JUMPF  = 5'd9,
        OP_STORE  = 5'd10,
        OP_LOAD   = 5'd11,
        OP_NEG    = 5'd12,
        OP_LNOT   = 5'd13,
        OP_LEFT   = 5'd14,
        OP_RIGHT  = 5'd15,
        OP_GOR    = 5'd16,
        OP_LI8    = 5'd17,
        OP_CALL   = 5'd18,
        OP_JUMP   = 5'd19,
        OP_RET    = 5'd20,
        OP_TRAP   = 5'd21,
        OP_ALLEN  = 5'd22,
        OP_POPEN  = 5'd23,
        OP_PUSHEN = 5'd24,
        OP_NOP    = 5'b11111
    } op_t;
endpackage

interface pipe_flow_ctrl_if;
    import pipe_flow_ctrl_pkg::*;

    op_t         op0;
    logic [3:0]  d0;
    logic [3:0]  s0;
    logic [3:0]  t0;
    logic [7:0]  imm0;
    logic        s1_wr;
    logic [3:0]  s1_dst;
    logic        s2_wr;
    logic [3:0]  s2_dst;
    logic        br_taken;
    logic [15:0] br_target;

    logic [15:0] pc;
    op_t         s1_op;
    logic [3:0]  s1_d;
    logic        stall;
    logic        squash;
    logic [2:0]  cs_depth;
    logic        cs_err;
    logic        halt;

    modport master (
        output op0, d0, s0, t0, imm0, s1_wr, s1_dst, s2_wr, s2_dst, br_taken, br_target,
        input  pc, s1_op, s1_d, stall, squash, cs_depth, cs_err, halt
    );

    modport slave (
        input  op0, d0, s0, t0, imm0, s1_wr, s1_dst, s2_wr, s2_dst, br_taken, br_target,
        output pc, s1_op, s1_d, stall, squash, cs_depth, cs_err, halt
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: PC, call stack, stage-0 -> stage-1 op register, hazard stall, redirect, halt.
// Latency: pc/s1_op/squash/cs_* update one cycle after the deciding inputs; stall is combinational.
// Backpressure: a register hazard holds pc and issues a bubble; halt freezes pc and the stack for good.
// Ports: clk, reset (async active-low), bus (pipe_flow_ctrl_if.slave) carrying decode inputs,
//   writeback hazard info, late branch redirect and all controller outputs.
module pipe_flow_ctrl
    import pipe_flow_ctrl_pkg::*;
#(
    parameter int          CS_DEPTH = 4,
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    pipe_flow_ctrl_if.slave bus
);
    localparam int         AW      = (CS_DEPTH > 1) ? $clog2(CS_DEPTH) : 1;
    localparam logic [2:0] CS_FULL = 3'(CS_DEPTH);

    logic [15:0] pc_q;
    op_t         s1_op_q;
    logic [3:0]  s1_d_q;
    logic        squash_q;
    logic [2:0]  depth_q;
    logic        cs_err_q;
    logic        halt_q;
    logic [15:0] cs_mem [CS_DEPTH];

    logic        rd_s, rd_t, rd_d;
    logic        hazard, stall_c;
    logic [15:0] pc_inc, pc_nxt;
    op_t         op_nxt;
    logic [3:0]  d_nxt;
    logic        push, pop, fault, trap_hit;
    logic [AW-1:0] push_idx, top_idx;

    function automatic logic reg_busy(input logic [3:0] r,
                                      input logic w1, input logic [3:0] d1,
                                      input logic w2, input logic [3:0] d2);
        return (w1 && (d1 == r)) || (w2 && (d2 == r));
    endfunction

    // Which register fields the stage-0 op actually reads.
    always_comb begin
        rd_s = 1'b0;
        rd_t = 1'b0;
        rd_d = 1'b0;
        case (bus.op0)
            OP_ADD, OP_AND, OP_MUL, OP_OR, OP_SLL, OP_SLT, OP_SRA, OP_XOR: begin
                rd_s = 1'b1;
                rd_t = 1'b1;
            end
            OP_LU8, OP_JUMPF: rd_d = 1'b1;
            OP_STORE: begin
                rd_d = 1'b1;
                rd_s = 1'b1;
            end
            OP_LOAD, OP_NEG, OP_LNOT, OP_LEFT, OP_RIGHT, OP_GOR: rd_s = 1'b1;
            default: ;
        endcase
    end

    assign hazard = (rd_s && reg_busy(bus.s0, bus.s1_wr, bus.s1_dst, bus.s2_wr, bus.s2_dst))
                 || (rd_t && reg_busy(bus.t0, bus.s1_wr, bus.s1_dst, bus.s2_wr, bus.s2_dst))
                 || (rd_d && reg_busy(bus.d0, bus.s1_wr, bus.s1_dst, bus.s2_wr, bus.s2_dst));

    // A redirect or halt makes the stage-0 instruction irrelevant, so it cannot stall.
    assign stall_c  = !halt_q && !bus.br_taken && hazard;
    assign pc_inc   = pc_q + 16'd1;
    assign push_idx = depth_q[AW-1:0];
    assign top_idx  = push_idx - AW'(1);

    always_comb begin
        pc_nxt   = pc_q;
        op_nxt   = s1_op_q;
        d_nxt    = s1_d_q;
        push     = 1'b0;
        pop      = 1'b0;
        fault    = 1'b0;
        trap_hit = 1'b0;
        if (halt_q) begin
            op_nxt = OP_NOP;
        end else if (bus.br_taken) begin
            pc_nxt = bus.br_target;
            op_nxt = OP_NOP;
        end else if (stall_c) begin
            op_nxt = OP_NOP;
        end else begin
            case (bus.op0)
                OP_JUMP: begin
                    pc_nxt = {pc_q[15:8], bus.imm0};
                    op_nxt = bus.op0;
                    d_nxt  = bus.d0;
                end
                OP_CALL: begin
                    if (depth_q == CS_FULL) begin
                        fault  = 1'b1;
                        op_nxt = OP_NOP;
                    end else begin
                        push   = 1'b1;
                        pc_nxt = {pc_q[15:8], bus.imm0};
                        op_nxt = bus.op0;
                        d_nxt  = bus.d0;
                    end
                end
                OP_RET: begin
                    if (depth_q == 3'd0) begin
                        fault  = 1'b1;
                        op_nxt = OP_NOP;
                    end else begin
                        pop    = 1'b1;
                        pc_nxt = cs_mem[top_idx];
                        op_nxt = bus.op0;
                        d_nxt  = bus.d0;
                    end
                end
                OP_TRAP: begin
                    trap_hit = 1'b1;
                    op_nxt   = bus.op0;
                    d_nxt    = bus.d0;
                end
                default: begin
                    pc_nxt = pc_inc;
                    op_nxt = bus.op0;
                    d_nxt  = bus.d0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= PC_RESET;
            s1_op_q  <= OP_NOP;
            s1_d_q   <= 4'd0;
            squash_q <= 1'b0;
            depth_q  <= 3'd0;
            cs_err_q <= 1'b0;
            halt_q   <= 1'b0;
            for (int i = 0; i < CS_DEPTH; i++) begin
                cs_mem[i] <= 16'd0;
            end
        end else begin
            pc_q     <= pc_nxt;
            s1_op_q  <= op_nxt;
            s1_d_q   <= d_nxt;
            squash_q <= bus.br_taken && !halt_q;
            cs_err_q <= cs_err_q || fault;
            halt_q   <= halt_q || fault || trap_hit;
            if (push) begin
                cs_mem[push_idx] <= pc_inc;
                depth_q          <= depth_q + 3'd1;
            end else if (pop) begin
                depth_q <= depth_q - 3'd1;
            end
        end
    end

    assign bus.pc       = pc_q;
    assign bus.s1_op    = s1_op_q;
    assign bus.s1_d     = s1_d_q;
    assign bus.stall    = stall_c;
    assign bus.squash   = squash_q;
    assign bus.cs_depth = depth_q;
    assign bus.cs_err   = cs_err_q;
    assign bus.halt     = halt_q;
endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Pipeline flow controller for the 16-bit pipelined processor. Owns the PC, the 4-entry return-address (call) stack and the stage-0 to stage-1 op register. Stalls on register hazards, redirects on jump/call/ret, squashes on late-resolved jumpf, and raises halt on trap or call-stack fault. Decode is combinational upstream. The register file, ALU and memories sit downstream and are sequenced by this block's pc and s1_op outputs.

Parameters:
CS_DEPTH, 4, call-stack entries (64-bit stack = 4 x 16-bit words)
PC_RESET, 16'h0000, PC value on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op0  input  5  decoded op of the instruction at pc (5-bit unique op space; 5'b11111 = nop)
d0  input  4  D field of instruction at pc
s0  input  4  S field
t0  input  4  T field
imm0  input  8  IMMED field
s1_wr  input  1  stage-1 instruction will write a register
s1_dst  input  4  its destination
s2_wr  input  1  stage-2 instruction will write a register
s2_dst  input  4  its destination
br_taken  input  1  stage-2 jumpf resolved taken (one-cycle pulse)
br_target  input  16  target for br_taken
pc  output  16  fetch address
s1_op  output  5  registered op issued to stage 1
s1_d  output  4  registered D field issued to stage 1
stall  output  1  hazard stall this cycle (combinational)
squash  output  1  registered; 1 for the cycle after br_taken
cs_depth  output  3  valid call-stack entries, 0..4
cs_err  output  1  sticky call-stack fault
halt  output  1  sticky halt

Behaviour:
- Reset (reset=0, async): pc=PC_RESET, s1_op=nop, s1_d=0, squash=0, cs_depth=0, stack contents=0, cs_err=0, halt=0.
- Source-read table for op0:
  - add, and, mul, or, sll, slt, sra, xor read S and T.
  - lu8, jumpf, store read D; store also reads S.
  - load, neg, lnot, left, right, gor read S.
  - li8, call, jump, ret, trap, allen, popen, pushen, nop read none.
  - No register is hazard-exempt.
- stall = !halt && !br_taken && any read reg == s1_dst (s1_wr) or == s2_dst (s2_wr).
- Per-cycle priority, highest first: halt > br_taken > stall > stage-0 control > sequential.
  - halt: pc, stack and s1_op hold. s1_op is forced to nop from the cycle after halt rises.
  - br_taken: pc<=br_target; s1_op<=nop; squash<=1 next cycle. The stage-0 op is discarded, including any call, ret or trap it carries.
  - stall: pc holds; s1_op<=nop (bubble). Stack is unchanged.
  - jump: pc<={pc[15:8],imm0}; s1_op<=jump. No bubble.
  - call: push pc+1, then pc<={pc[15:8],imm0}.
    - Push at cs_depth==4: no push, cs_err<=1, halt<=1.
  - ret: pop into pc.
    - Pop at cs_depth==0: pc holds, cs_err<=1, halt<=1.
  - trap: halt<=1; s1_op<=trap; pc holds.
  - Otherwise: pc<=pc+1 with 16-bit wrap (FFFF->0000); s1_op<=op0; s1_d<=d0.
- The stack is LIFO. The top is the most recent push. cs_depth reflects the registered state.
- squash is exactly one cycle wide. Back-to-back br_taken pulses each redirect, and squash stays high.
- Reset asserted mid-operation clears everything, including sticky bits, immediately.

Test Plan:
- Reset then 3 cycles of op0=add, no hazards -> pc 0,1,2,3; s1_op=add; stall=0.
- op0=add, s0=4, s1_wr=1, s1_dst=4 for 2 cycles -> stall=1, pc held at N, s1_op=nop twice. On release, pc=N+1.
- At pc=0x1234, op0=call, imm0=0x50 -> pc=0x1250, cs_depth=1. Then op0=ret -> pc=0x1235, cs_depth=0.
- Five nested calls -> 5th sets cs_err=1 and halt=1, cs_depth stays 4, pc frozen. ret at depth 0 gives the same fault.
- op0=call coincident with br_taken, br_target=0x0400 -> pc=0x0400, cs_depth unchanged, s1_op=nop, squash=1 next cycle only.
- pc=0xFFFF with op0=nop -> pc=0x0000. op0=trap -> halt=1, stays high until reset=0, then clears asynchronously.
